// File: rtl/sdram_arbiter.sv
// Three-port arbiter and sequencer in front of the single-port SDRAM controller.
// It gates traffic on controller init, grants one client at a time and turns level requests into strobes.
module sdram_arbiter #(
  parameter bit RR_ENABLE = 1'b1,
  parameter int TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  c_req,
  input  logic [2:0]  c_we,
  input  logic [74:0] c_addr,
  input  logic [5:0]  c_be,
  input  logic [47:0] c_wdata,
  output logic [2:0]  c_ack,
  output logic [2:0]  c_err,
  output logic [15:0] c_rdata,
  output logic [24:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [1:0]  mem_word,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  input  logic        mem_ack,
  input  logic        mem_busy,
  input  logic        mem_configdone
);

  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_ISSUE, ST_WAIT, ST_GAP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  last_grant, grant, winner, search_base, offset;
  logic [2:0]  req_rot, sum, sum_wrap, grant_hot;
  logic [15:0] count;
  logic [16:0] count_inc;
  logic        take, done_ack, done_tmo;
  logic [24:0] sel_addr;
  logic [1:0]  sel_be;
  logic [15:0] sel_wdata;
  logic        sel_we;

  // Search starts one past the last successful grant, or always at port 0.
  assign search_base = !RR_ENABLE          ? 2'd0 :
                       (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
  assign count_inc   = {1'b0, count} + 17'd1;
  assign grant_hot   = 3'b001 << grant;

  always_comb begin
    // NOTE: every comb output gets a default up front so no path can infer a latch.
    req_rot = c_req;
    offset  = 2'd2;
    case (search_base)
      2'd1:    req_rot = {c_req[0], c_req[2], c_req[1]};
      2'd2:    req_rot = {c_req[1], c_req[0], c_req[2]};
      default: req_rot = c_req;
    endcase
    if (req_rot[0])      offset = 2'd0;
    else if (req_rot[1]) offset = 2'd1;
    sum      = {1'b0, search_base} + {1'b0, offset};
    sum_wrap = sum - 3'd3;
    winner   = (sum >= 3'd3) ? sum_wrap[1:0] : sum[1:0];
  end

  always_comb begin
    sel_addr  = c_addr[24:0];
    sel_be    = c_be[1:0];
    sel_wdata = c_wdata[15:0];
    sel_we    = c_we[0];
    case (winner)
      2'd1: begin
        sel_addr  = c_addr[49:25];
        sel_be    = c_be[3:2];
        sel_wdata = c_wdata[31:16];
        sel_we    = c_we[1];
      end
      2'd2: begin
        sel_addr  = c_addr[74:50];
        sel_be    = c_be[5:4];
        sel_wdata = c_wdata[47:32];
        sel_we    = c_we[2];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    done_ack  = 1'b0;
    done_tmo  = 1'b0;
    case (state)
      ST_INIT:  if (mem_configdone) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (!mem_configdone) begin
          state_nxt = ST_INIT;
        end else if ((|c_req) && !mem_busy) begin
          take      = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        // An ack landing on the same cycle as the limit wins over the abort.
        if (mem_ack) begin
          done_ack  = 1'b1;
          state_nxt = ST_GAP;
        end else if (count_inc == 17'(TIMEOUT)) begin
          done_tmo  = 1'b1;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_INIT;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_ack      <= '0;
      c_err      <= '0;
      c_rdata    <= '0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_word   <= '0;
      mem_din    <= '0;
      last_grant <= 2'd2;
      grant      <= 2'd0;
      count      <= '0;
    end else begin
      c_ack <= '0;
      c_err <= '0;
      if (take) begin
        grant    <= winner;
        mem_addr <= sel_addr;
        mem_word <= sel_be;
        mem_din  <= sel_wdata;
        mem_rd   <= ~sel_we;
        mem_wr   <= sel_we;
      end
      if (state == ST_ISSUE) count <= '0;
      if (state == ST_WAIT)  count <= count_inc[15:0];
      if (done_ack) begin
        mem_rd     <= 1'b0;
        mem_wr     <= 1'b0;
        c_ack      <= grant_hot;
        last_grant <= grant;
        if (mem_rd) c_rdata <= mem_dout;
      end else if (done_tmo) begin
        mem_rd <= 1'b0;
        mem_wr <= 1'b0;
        c_ack  <= grant_hot;
        c_err  <= grant_hot;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: a round-robin and a fixed-priority instance share one controller model,
// and every access is predicted from the arbitration rules at transaction level.
module tb_sdram_arbiter;
  localparam int T = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic cfg   = 1'b0;
  int   sel   = 0;
  always #5 clk = ~clk;

  logic [2:0]  req = '0;
  logic [24:0] addr [3];
  logic        we   [3];
  logic [1:0]  be   [3];
  logic [15:0] wd   [3];

  logic [74:0] c_addr;
  logic [2:0]  c_we;
  logic [5:0]  c_be;
  logic [47:0] c_wdata;
  always_comb begin
    c_addr = '0; c_we = '0; c_be = '0; c_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      c_addr[25*i +: 25]  = addr[i];
      c_we[i]             = we[i];
      c_be[2*i +: 2]      = be[i];
      c_wdata[16*i +: 16] = wd[i];
    end
  end

  logic        mem_ack  = 1'b0;
  logic        mem_busy = 1'b0;
  logic [15:0] mem_dout = '0;

  logic [2:0]  req_r, req_f, c_ack_r, c_ack_f, c_err_r, c_err_f;
  logic [15:0] c_rdata_r, c_rdata_f, mem_din_r, mem_din_f;
  logic [24:0] mem_addr_r, mem_addr_f;
  logic        mem_rd_r, mem_rd_f, mem_wr_r, mem_wr_f;
  logic [1:0]  mem_word_r, mem_word_f;
  assign req_r = (sel == 0) ? req : 3'b000;
  assign req_f = (sel == 1) ? req : 3'b000;

  sdram_arbiter #(.RR_ENABLE(1'b1), .TIMEOUT(T)) u_rr (
    .clk(clk), .reset(reset), .c_req(req_r), .c_we(c_we), .c_addr(c_addr), .c_be(c_be),
    .c_wdata(c_wdata), .c_ack(c_ack_r), .c_err(c_err_r), .c_rdata(c_rdata_r),
    .mem_addr(mem_addr_r), .mem_rd(mem_rd_r), .mem_wr(mem_wr_r), .mem_word(mem_word_r),
    .mem_din(mem_din_r), .mem_dout(mem_dout), .mem_ack(mem_ack), .mem_busy(mem_busy),
    .mem_configdone(cfg));

  sdram_arbiter #(.RR_ENABLE(1'b0), .TIMEOUT(T)) u_fp (
    .clk(clk), .reset(reset), .c_req(req_f), .c_we(c_we), .c_addr(c_addr), .c_be(c_be),
    .c_wdata(c_wdata), .c_ack(c_ack_f), .c_err(c_err_f), .c_rdata(c_rdata_f),
    .mem_addr(mem_addr_f), .mem_rd(mem_rd_f), .mem_wr(mem_wr_f), .mem_word(mem_word_f),
    .mem_din(mem_din_f), .mem_dout(mem_dout), .mem_ack(mem_ack), .mem_busy(mem_busy),
    .mem_configdone(cfg));

  logic [2:0]  c_ack, c_err;
  logic [15:0] c_rdata, mem_din;
  logic [24:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [1:0]  mem_word;
  assign c_ack    = (sel == 0) ? c_ack_r    : c_ack_f;
  assign c_err    = (sel == 0) ? c_err_r    : c_err_f;
  assign c_rdata  = (sel == 0) ? c_rdata_r  : c_rdata_f;
  assign mem_addr = (sel == 0) ? mem_addr_r : mem_addr_f;
  assign mem_rd   = (sel == 0) ? mem_rd_r   : mem_rd_f;
  assign mem_wr   = (sel == 0) ? mem_wr_r   : mem_wr_f;
  assign mem_word = (sel == 0) ? mem_word_r : mem_word_f;
  assign mem_din  = (sel == 0) ? mem_din_r  : mem_din_f;

  // Controller model: acks lat_cfg cycles after a strobe rise, busy while a strobe is serviced.
  int          lat_cfg    = 4;
  int          ctr        = 0;
  bit          active     = 1'b0;
  bit          prev_strb  = 1'b0;
  bit          busy_force = 1'b0;
  logic [15:0] next_dout  = '0;
  logic [15:0] ack_dout   = '0;
  always @(negedge clk) begin
    if (mem_rd || mem_wr) begin
      if (!prev_strb) begin
        active   = 1'b1;
        ctr      = 0;
        ack_dout = next_dout;
      end else if (active) begin
        ctr++;
      end
    end else begin
      active = 1'b0;
    end
    prev_strb = mem_rd || mem_wr;
    mem_ack   = active && (ctr == lat_cfg);
    mem_dout  = mem_ack ? ack_dout : 16'($urandom);
    mem_busy  = active || busy_force;
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  int          lg_m [2];
  logic [15:0] exp_rdata [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [2:0] r, input int lg, input bit rr);
    int start;
    start = rr ? (lg + 1) % 3 : 0;
    for (int k = 0; k < 3; k++) begin
      if (r[(start + k) % 3]) return (start + k) % 3;
    end
    return -1;
  endfunction

  task automatic new_fields(input int i);
    addr[i] = {23'($urandom), 2'(i)};
    we[i]   = 1'($urandom);
    be[i]   = 2'($urandom);
    wd[i]   = 16'($urandom);
  endtask

  // One access: predict the winner, check the issued fields, strobe length and completion.
  task automatic serve(input int lat, input logic [15:0] dout, input string tag, output int gp);
    int n, exp_len, stray;
    bit tmo;
    lat_cfg   = lat;
    next_dout = dout;
    gp        = -1;
    n = 0;
    while (!(mem_rd || mem_wr) && n < 400) begin @(negedge clk); n++; end
    if (!(mem_rd || mem_wr)) begin
      check({tag, "_strobe_wait"}, 32'(n), 32'(0));
      return;
    end
    gp = pick(req, lg_m[sel], sel == 0);
    if (gp < 0) begin
      check({tag, "_unrequested_strobe"}, {mem_rd, mem_wr}, 2'b00);
      return;
    end
    check({tag, "_addr"}, mem_addr, addr[gp]);
    check({tag, "_rdwr"}, {mem_rd, mem_wr}, {~we[gp], we[gp]});
    check({tag, "_word"}, mem_word, be[gp]);
    check({tag, "_din"},  mem_din,  wd[gp]);
    n = 0; stray = 0;
    while ((mem_rd || mem_wr) && n < 100) begin
      if (c_ack != 3'b000) stray++;
      n++;
      @(negedge clk);
    end
    tmo     = lat > T;
    exp_len = tmo ? T + 1 : lat + 1;
    check({tag, "_early_ack"}, 32'(stray), 32'(0));
    check({tag, "_strobe_len"}, 32'(n), 32'(exp_len));
    check({tag, "_ack"}, c_ack, 32'(1) << gp);
    check({tag, "_err"}, c_err, tmo ? (32'(1) << gp) : 32'(0));
    if (!tmo) begin
      if (!we[gp]) exp_rdata[sel] = dout;
      lg_m[sel] = gp;
    end
    check({tag, "_rdata"}, c_rdata, exp_rdata[sel]);
  endtask

  // Client reaction in the ack cycle: 0 drop, 1 refresh, 2 random, 3 drop all.
  task automatic client_update(input int gp, input int mode);
    if (mode == 0) begin
      req[gp] = 1'b0;
    end else if (mode == 1) begin
      new_fields(gp);
    end else if (mode == 3) begin
      req = '0;
    end else begin
      if ($urandom_range(1, 0) == 1) new_fields(gp);
      else req[gp] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (!req[i] && $urandom_range(2, 0) == 0) begin new_fields(i); req[i] = 1'b1; end
      end
      if (req == 3'b000) begin
        int k;
        k = $urandom_range(2, 0);
        new_fields(k);
        req[k] = 1'b1;
      end
    end
    @(negedge clk);
    check("ack_one_cycle", c_ack, 3'b000);
  endtask

  task automatic random_phase(input int count, input string tag);
    int gp;
    for (int i = 0; i < 3; i++) begin new_fields(i); req[i] = 1'($urandom); end
    if (req == 3'b000) req[0] = 1'b1;
    for (int n = 0; n < count; n++) begin
      serve($urandom_range(T + 3, 2), 16'($urandom), tag, gp);
      if (gp < 0) break;
      client_update(gp, 2);
    end
    req = '0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gp, n, stray;
    for (int i = 0; i < 3; i++) new_fields(i);
    lg_m[0] = 2; lg_m[1] = 2;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    repeat (3) @(negedge clk);
    check("rst_ack",    c_ack,    3'b000);
    check("rst_err",    c_err,    3'b000);
    check("rst_rdata",  c_rdata,  16'h0);
    check("rst_strobe", {mem_rd, mem_wr, mem_rd_f, mem_wr_f}, 4'b0000);
    check("rst_fields", {mem_addr, mem_word, mem_din}, 43'h0);
    reset = 1'b0;

    // Init gating with every port requesting, then continuous round-robin.
    req = 3'b111; stray = 0;
    repeat (100) begin @(negedge clk); if (mem_rd || mem_wr) stray++; end
    check("init_gate", 32'(stray), 32'(0));
    cfg = 1'b1;
    for (int k = 0; k < 6; k++) begin
      serve($urandom_range(10, 2), 16'($urandom), "rr_cont", gp);
      if (gp < 0) break;
      client_update(gp, (k == 5) ? 3 : 1);
    end
    req = '0;

    addr[0] = 25'h0001234; we[0] = 1'b0; be[0] = 2'b11; req = 3'b001;
    serve(8, 16'hBEEF, "single_rd", gp);
    check("single_rd_beef", c_rdata, 16'hBEEF);
    if (gp >= 0) client_update(gp, 0);

    addr[1] = 25'h1000000; we[1] = 1'b1; be[1] = 2'b11; wd[1] = 16'h5A5A; req = 3'b010;
    serve(6, 16'h1111, "write", gp);
    check("write_rdata_kept", c_rdata, 16'hBEEF);
    if (gp >= 0) client_update(gp, 0);

    new_fields(2); we[2] = 1'b0; req = 3'b100;
    serve(1000, 16'h2222, "timeout", gp);
    if (gp >= 0) client_update(gp, 1);
    serve(T, 16'h3333, "tie_ack_wins", gp);
    if (gp >= 0) client_update(gp, 1);
    serve(T + 1, 16'h4444, "one_past", gp);
    if (gp >= 0) client_update(gp, 1);
    serve(4, 16'($urandom), "after_tmo", gp);
    if (gp >= 0) client_update(gp, 0);

    // Reset in WAIT while the controller stays busy.
    new_fields(1); we[1] = 1'b0; req = 3'b010; lat_cfg = 1000;
    n = 0;
    while (!(mem_rd || mem_wr) && n < 50) begin @(negedge clk); n++; end
    check("rst_mid_strobe_up", mem_rd || mem_wr, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1; busy_force = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_strobe_low", {mem_rd, mem_wr}, 2'b00);
    check("rst_mid_no_ack", c_ack, 3'b000);
    check("rst_mid_rdata", c_rdata, 16'h0);
    lg_m[0] = 2; lg_m[1] = 2;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    stray = 0;
    repeat (6) begin @(negedge clk); if (mem_rd || mem_wr || c_ack != 3'b000) stray++; end
    check("rst_mid_busy_hold", 32'(stray), 32'(0));
    busy_force = 1'b0;
    serve(5, 16'($urandom), "post_rst", gp);
    if (gp >= 0) client_update(gp, 0);

    random_phase(40, "rr_rand");

    // Fixed priority: port 0 keeps re-requesting, then drains.
    @(negedge clk);
    sel = 1;
    for (int i = 0; i < 3; i++) new_fields(i);
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      serve($urandom_range(10, 2), 16'($urandom), "fp", gp);
      if (gp < 0) break;
      client_update(gp, (k < 3) ? 1 : 0);
    end
    random_phase(30, "fp_rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
